// File: rtl/sap1_pkg.sv
// Shared types and constants for the SAP-1 program/data RAM block.
package sap1_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    localparam logic MODE_LOAD = 1'b0;
    localparam logic MODE_EXEC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        WRITE = 2'd2,
        REL   = 2'd3
    } ram_state_t;

endpackage

// File: rtl/memoria_ram_if.sv
// Operator/controller-facing signals of the RAM: mode, address, switch data,
// write button, read enable, bus read data/drive enable and write pulse.
interface memoria_ram_if;
    import sap1_pkg::*;

    logic              ch_s4;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] d;
    logic              wr_btn;
    logic              n_ce;
    logic [DATA_W-1:0] s_out;
    logic              s_oe;
    logic              wr_done;

    modport master (
        output ch_s4, addr, d, wr_btn, n_ce,
        input  s_out, s_oe, wr_done
    );

    modport slave (
        input  ch_s4, addr, d, wr_btn, n_ce,
        output s_out, s_oe, wr_done
    );

endinterface

// File: rtl/debounce_sync.sv
// Write-button synchroniser, debouncer and write-sequencing FSM.
//
// state | meaning
// IDLE  | waiting for a synchronised press while in load mode
// PRESS | counting consecutive high samples; low sample or exec mode aborts
// WRITE | single-cycle write strobe
// REL   | waiting for DB_CYCLES consecutive low samples before re-arming
module debounce_sync
    import sap1_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic n_clr,
    input  logic wr_btn,
    input  logic ch_s4,
    output logic wr_done
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             btn_m;
    logic             btn_s;
    ram_state_t       state;
    ram_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchroniser for the raw asynchronous pushbutton
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= wr_btn;
            btn_s <= btn_m;
        end
    end

    // FSM state and debounce counter registers
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (btn_s && (ch_s4 == MODE_LOAD)) begin
                    state_nxt = PRESS;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (ch_s4 == MODE_EXEC) begin
                    state_nxt = REL;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = WRITE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            WRITE: begin
                state_nxt = REL;
                cnt_nxt   = '0;
            end
            REL: begin
                if (btn_s) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Strobe decoded straight from the state register, so it is clean and one cycle wide
    assign wr_done = (state == WRITE);

endmodule

// File: rtl/memoria_ram.sv
// 16x8 SAP-1 program/data RAM: button-driven writes in load mode,
// combinational reads toward the main bus in execute mode.
module memoria_ram
    import sap1_pkg::*;
#(
    parameter int DB_CYCLES = 16,
    parameter int DEPTH     = 16,
    parameter int WIDTH     = DATA_W
) (
    input  logic          clk,
    input  logic          n_clr,
    memoria_ram_if.slave  bus
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_stb;

    debounce_sync #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce_sync (
        .clk     (clk),
        .n_clr   (n_clr),
        .wr_btn  (bus.wr_btn),
        .ch_s4   (bus.ch_s4),
        .wr_done (wr_stb)
    );

    // Storage write; deliberately not reset so a program survives a CPU clear
    always_ff @(posedge clk) begin
        if (wr_stb) begin
            mem[bus.addr] <= bus.d;
        end
    end

    assign bus.s_out   = mem[bus.addr];
    assign bus.s_oe    = (bus.ch_s4 == MODE_EXEC) & ~bus.n_ce;
    assign bus.wr_done = wr_stb;

endmodule
